pid_channel_scheduler: RTL and testbench
========================================

// Module: pid_channel_scheduler
// PURPOSE
//  Time-multiplexes one shared pid_core between N_CHAN input channels (oversample filter outputs).
//  - Latches each channel's newest sample and grants the core round-robin.
//  - Tags each issue with a channel index so the coefficient bank and memory can be selected.
//  - Waits for the core result and routes it downstream with its channel tag.
//  - Sits between the oversample filters and pid_core; its output feeds the source mux.
// PARAMETERS
//  N_CHAN    8    number of requesting channels (2..16)
//  W_CHAN    3    channel index width, >= clog2(N_CHAN)
//  W_IN      18   sample width
//  W_OUT     64   pid result width
//  TIMEOUT   255  max cycles to wait for a pid result before abandoning (1..255)
// PORTS
//  clk_in          in   1             system clock
//  reset_in        in   1             synchronous active-high reset
//  chan_data_in    in   N_CHAN*W_IN   packed samples, channel k at [k*W_IN +: W_IN]
//  chan_valid_in   in   N_CHAN        per-channel sample strobe
//  chan_en_in      in   N_CHAN        per-channel enable (frontpanel)
//  pid_data_out    out  W_IN          sample to pid_core data_in
//  pid_valid_out   out  1             one-cycle issue strobe to pid_core
//  pid_chan_out    out  W_CHAN        channel being serviced, held from issue to completion
//  pid_data_in     in   W_OUT         pid_core data_out
//  pid_valid_in    in   1             pid_core data_valid_out
//  data_out        out  W_OUT         routed result
//  chan_out        out  W_CHAN        channel tag of data_out
//  data_valid_out  out  1             one-cycle result strobe
//  busy_out        out  1             high in every state except ST_IDLE
//  timeout_out     out  1             one-cycle pulse when a wait is abandoned
// BEHAVIOUR
//  - Reset: every output 0; all pending bits 0; rr pointer 0; state ST_IDLE.
//  - Per-channel pending latch:
//    - chan_valid_in[k] & chan_en_in[k] -> capture sample k, set pending[k] next cycle.
//    - A newer sample overwrites an un-issued one (latest wins).
//    - chan_en_in[k]=0 clears pending[k] and blocks grant to k.
//  - FSM, 2-bit:
//    - ST_IDLE:  if any pending, pick the first pending channel scanning from rr_ptr upward (modulo N_CHAN).
//      Register its sample and index, clear its pending bit, set rr_ptr = grant+1 (wrap to 0 past N_CHAN-1). -> ST_ISSUE.
//    - ST_ISSUE: pid_valid_out=1 for exactly this cycle; clear wait counter. -> ST_WAIT.
//    - ST_WAIT:  pid_valid_in -> capture pid_data_in -> ST_DONE.
//      Counter reaches TIMEOUT-1 without pid_valid_in -> pulse timeout_out -> ST_IDLE, no result.
//    - ST_DONE:  data_out / chan_out driven; data_valid_out=1 for this cycle. -> ST_IDLE.
//  - Latency:
//    - chan_valid_in at cycle T on an idle scheduler -> pid_valid_out at T+2.
//    - pid_valid_in at R -> data_valid_out at R+1.
//    - Next issue no earlier than R+3.
//  - pid_chan_out is stable from ST_ISSUE through ST_DONE.
//  - data_out and chan_out hold their last values outside ST_DONE.
//  - pid_valid_in outside ST_WAIT is ignored (stray/late result after a timeout is dropped).
//  - Simultaneous events:
//    - New sample on the granted channel in the grant cycle: pending stays set (set wins over clear) with the new data.
//    - chan_en_in dropped while that channel is in flight: the current transaction completes normally.
//  - Reset mid-operation: abort immediately to ST_IDLE, no data_valid_out. pid_core shares reset_in.
//  - Sample and result are passed unmodified; no arithmetic or width change.
// CONFIGURATION
//  PID_SCHED_OVERRUN_EN defined:
//    - Adds ports overrun_clr_in (in, 1) and overrun_out (out, N_CHAN).
//    - overrun_out[k] is a sticky flag, set when a sample arrives for k while pending[k] is already set.
//    - Cleared by overrun_clr_in or reset; set wins over clear in the same cycle.
//  Not defined: ports absent, overwrite is silent.
// TESTING
//  1. Reset, then chan 2 valid at T with data 18'h00123, all enabled
//     -> pid_valid_out at T+2, pid_data_out=0x123, pid_chan_out=2.
//  2. Chans 0, 3, 5 valid in the same cycle; pid stub returns after 1 cycle
//     -> issue order 0, 3, 5; then a new chan 0 sample is issued after 5 (wrap).
//  3. Stub returns 64'hDEAD_BEEF 4 cycles after issue
//     -> data_out=DEADBEEF, chan_out=issued channel, one-cycle data_valid_out one cycle after return.
//  4. TIMEOUT=10, stub never responds -> timeout_out pulse 10 cycles after ST_ISSUE, busy_out low next cycle.
//     A late pid_valid_in is then ignored.
//  5. Chan 1 disabled with pending; chan 4 enabled pending -> only chan 4 issued, pending[1] cleared.
//  6. reset_in asserted during ST_WAIT -> outputs 0 next cycle, no data_valid_out.
//     With PID_SCHED_OVERRUN_EN: two chan 6 samples before grant -> overrun_out[6]=1 until overrun_clr_in.

Source files
------------

// File: rtl/pid_channel_scheduler.sv
// Round-robin scheduler that shares one pid_core between N_CHAN sample channels.
// Optional sticky per-channel overrun flags when PID_SCHED_OVERRUN_EN is defined.
module pid_channel_scheduler #(
  parameter int N_CHAN  = 8,
  parameter int W_CHAN  = 3,
  parameter int W_IN    = 18,
  parameter int W_OUT   = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [N_CHAN*W_IN-1:0]   chan_data_in,
  input  logic [N_CHAN-1:0]        chan_valid_in,
  input  logic [N_CHAN-1:0]        chan_en_in,
  output logic [W_IN-1:0]          pid_data_out,
  output logic                     pid_valid_out,
  output logic [W_CHAN-1:0]        pid_chan_out,
  input  logic [W_OUT-1:0]         pid_data_in,
  input  logic                     pid_valid_in,
  output logic [W_OUT-1:0]         data_out,
  output logic [W_CHAN-1:0]        chan_out,
  output logic                     data_valid_out,
  output logic                     busy_out,
`ifdef PID_SCHED_OVERRUN_EN
  input  logic                     overrun_clr_in,
  output logic [N_CHAN-1:0]        overrun_out,
`endif
  output logic                     timeout_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [W_CHAN-1:0] LAST_CHAN = W_CHAN'(N_CHAN - 1);
  localparam logic [7:0]        WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_reg;
  logic [W_CHAN-1:0] rr_ptr_reg;
  logic [7:0]        wait_cnt_reg;
  logic [W_IN-1:0]   pid_data_reg;
  logic [W_CHAN-1:0] pid_chan_reg;
  logic [W_OUT-1:0]  data_out_reg;
  logic [W_CHAN-1:0] chan_out_reg;

  logic [W_IN-1:0]   sample_reg [N_CHAN];
  logic [N_CHAN-1:0] pending_reg;
  logic [N_CHAN-1:0] pending_next;
  logic [N_CHAN-1:0] capture;
  logic [N_CHAN-1:0] eligible;

  logic              grant_valid;
  logic              grant_fire;
  logic [W_CHAN-1:0] grant_idx;
  logic [W_IN-1:0]   grant_sample;
  logic              hi_found, lo_found;
  logic [W_CHAN-1:0] hi_idx, lo_idx;
  logic [W_IN-1:0]   hi_sample, lo_sample;

  assign eligible   = pending_reg & chan_en_in;
  assign grant_fire = (state_reg == ST_IDLE) && grant_valid;

  // A fresh capture wins over both the grant clear and the disable clear.
  generate
    for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_pending
      assign capture[gi]      = chan_valid_in[gi] & chan_en_in[gi];
      assign pending_next[gi] = capture[gi] |
                                (pending_reg[gi] & chan_en_in[gi] &
                                 ~(grant_fire && (grant_idx == W_CHAN'(gi))));
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    for (int k = 0; k < N_CHAN; k++) begin
      if (capture[k]) sample_reg[k] <= chan_data_in[k*W_IN +: W_IN];
    end
  end

  // Channels at or above rr_ptr take priority over those below (wrap-around scan).
  always_comb begin
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    hi_sample = '0;
    lo_sample = '0;
    for (int k = N_CHAN - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        if (W_CHAN'(k) >= rr_ptr_reg) begin
          hi_found  = 1'b1;
          hi_idx    = W_CHAN'(k);
          hi_sample = sample_reg[k];
        end else begin
          lo_found  = 1'b1;
          lo_idx    = W_CHAN'(k);
          lo_sample = sample_reg[k];
        end
      end
    end
    grant_valid  = hi_found | lo_found;
    grant_idx    = hi_found ? hi_idx : lo_idx;
    grant_sample = hi_found ? hi_sample : lo_sample;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      pending_reg  <= '0;
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= '0;
      wait_cnt_reg <= '0;
      pid_data_reg <= '0;
      pid_chan_reg <= '0;
      data_out_reg <= '0;
      chan_out_reg <= '0;
    end else begin
      pending_reg <= pending_next;
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            pid_data_reg <= grant_sample;
            pid_chan_reg <= grant_idx;
            rr_ptr_reg   <= (grant_idx == LAST_CHAN) ? '0 : grant_idx + 1'b1;
            state_reg    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt_reg <= '0;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (pid_valid_in) begin
            data_out_reg <= pid_data_in;
            chan_out_reg <= pid_chan_reg;
            state_reg    <= ST_DONE;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            state_reg <= ST_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign pid_data_out   = pid_data_reg;
  assign pid_chan_out   = pid_chan_reg;
  assign pid_valid_out  = (state_reg == ST_ISSUE);
  assign data_out       = data_out_reg;
  assign chan_out       = chan_out_reg;
  assign data_valid_out = (state_reg == ST_DONE);
  assign busy_out       = (state_reg != ST_IDLE);
  assign timeout_out    = (state_reg == ST_WAIT) && !pid_valid_in &&
                          (wait_cnt_reg == WAIT_LAST);

`ifdef PID_SCHED_OVERRUN_EN
  logic [N_CHAN-1:0] overrun_reg;
  logic [N_CHAN-1:0] overrun_next;

  generate
    for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_overrun
      assign overrun_next[gi] = (capture[gi] & pending_reg[gi]) |
                                (overrun_reg[gi] & ~overrun_clr_in);
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (reset_in) overrun_reg <= '0;
    else          overrun_reg <= overrun_next;
  end

  assign overrun_out = overrun_reg;
`endif

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Directed self-checking bench for pid_channel_scheduler (TIMEOUT=10 build).
module tb_pid_channel_scheduler;

  logic          clk;
  logic          reset_in;
  logic [143:0]  chan_data_in;
  logic [7:0]    chan_valid_in;
  logic [7:0]    chan_en_in;
  logic [17:0]   pid_data_out;
  logic          pid_valid_out;
  logic [2:0]    pid_chan_out;
  logic [63:0]   pid_data_in;
  logic          pid_valid_in;
  logic [63:0]   data_out;
  logic [2:0]    chan_out;
  logic          data_valid_out;
  logic          busy_out;
  logic          timeout_out;
`ifdef PID_SCHED_OVERRUN_EN
  logic          overrun_clr_in;
  logic [7:0]    overrun_out;
`endif

  int checks_total  = 0;
  int checks_passed = 0;

  pid_channel_scheduler #(
    .N_CHAN(8), .W_CHAN(3), .W_IN(18), .W_OUT(64), .TIMEOUT(10)
  ) dut (
    .clk_in(clk),
    .reset_in(reset_in),
    .chan_data_in(chan_data_in),
    .chan_valid_in(chan_valid_in),
    .chan_en_in(chan_en_in),
    .pid_data_out(pid_data_out),
    .pid_valid_out(pid_valid_out),
    .pid_chan_out(pid_chan_out),
    .pid_data_in(pid_data_in),
    .pid_valid_in(pid_valid_in),
    .data_out(data_out),
    .chan_out(chan_out),
    .data_valid_out(data_valid_out),
    .busy_out(busy_out),
`ifdef PID_SCHED_OVERRUN_EN
    .overrun_clr_in(overrun_clr_in),
    .overrun_out(overrun_out),
`endif
    .timeout_out(timeout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input int k, input logic [17:0] d);
    chan_data_in[k*18 +: 18] = d;
    chan_valid_in[k] = 1'b1;
  endtask

  task automatic apply_reset;
    reset_in = 1'b1;
    chan_valid_in = '0;
    pid_valid_in = 1'b0;
    tick;
    tick;
    reset_in = 1'b0;
  endtask

  // Waits (bounded) for an issue strobe; leaves time in the issue cycle.
  task automatic wait_issue(output bit found, output logic [2:0] ch, output logic [17:0] d);
    found = 1'b0;
    ch = '0;
    d = '0;
    for (int i = 0; i < 30; i++) begin
      if (pid_valid_out) begin
        found = 1'b1;
        ch = pid_chan_out;
        d = pid_data_out;
        break;
      end
      tick;
    end
  endtask

  // From the issue cycle, returns a result dly cycles later; samples in the done cycle.
  task automatic respond(input int dly, input logic [63:0] v, output logic dv,
                         output logic [63:0] dat, output logic [2:0] ch);
    repeat (dly) tick;
    pid_valid_in = 1'b1;
    pid_data_in = v;
    tick;
    pid_valid_in = 1'b0;
    dv = data_valid_out;
    dat = data_out;
    ch = chan_out;
  endtask

  task automatic test_reset;
    chan_data_in = '0;
    chan_en_in = 8'hFF;
    pid_data_in = '0;
`ifdef PID_SCHED_OVERRUN_EN
    overrun_clr_in = 1'b0;
`endif
    apply_reset;
    checks_total++;
    if ({pid_valid_out, data_valid_out, busy_out, timeout_out} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000",
               {pid_valid_out, data_valid_out, busy_out, timeout_out});
    else checks_passed++;
    checks_total++;
    if ({pid_data_out, pid_chan_out, data_out, chan_out} !== '0)
      $display("FAIL reset_data: got %0h/%0h/%0h/%0h expected all 0",
               pid_data_out, pid_chan_out, data_out, chan_out);
    else checks_passed++;
    tick;
    tick;
    checks_total++;
    if (busy_out !== 1'b0) $display("FAIL reset_no_pending: busy got %b expected 0", busy_out);
    else checks_passed++;
    $display("test_reset done");
  endtask

  task automatic test_single;
    logic dv; logic [63:0] dat; logic [2:0] ch;
    set_sample(2, 18'h00123);
    tick;
    chan_valid_in = '0;
    checks_total++;
    if (pid_valid_out !== 1'b0) $display("FAIL single_early: pid_valid got %b expected 0", pid_valid_out);
    else checks_passed++;
    tick;
    checks_total++;
    if ({pid_valid_out, pid_chan_out, pid_data_out} !== {1'b1, 3'd2, 18'h00123})
      $display("FAIL single_issue: got v=%b ch=%0d d=%0h expected v=1 ch=2 d=123",
               pid_valid_out, pid_chan_out, pid_data_out);
    else checks_passed++;
    respond(1, 64'h2, dv, dat, ch);
    checks_total++;
    if ({dv, dat, ch} !== {1'b1, 64'h2, 3'd2})
      $display("FAIL single_result: got dv=%b d=%0h ch=%0d expected 1/2/2", dv, dat, ch);
    else checks_passed++;
    tick;
    $display("test_single done");
  endtask

  task automatic test_round_robin;
    bit f; logic [2:0] c; logic [17:0] d;
    logic dv; logic [63:0] dat; logic [2:0] ch;
    logic [2:0] exp_ch [5];
    logic [17:0] exp_d [5];
    exp_ch = '{3'd0, 3'd3, 3'd5, 3'd7, 3'd0};
    exp_d  = '{18'h000A0, 18'h000A3, 18'h000A5, 18'h000B7, 18'h000B0};
    apply_reset;
    set_sample(0, 18'h000A0);
    set_sample(3, 18'h000A3);
    set_sample(5, 18'h000A5);
    tick;
    chan_valid_in = '0;
    for (int i = 0; i < 5; i++) begin
      wait_issue(f, c, d);
      checks_total++;
      if ({f, c, d} !== {1'b1, exp_ch[i], exp_d[i]})
        $display("FAIL rr_order_%0d: got found=%b ch=%0d d=%0h expected ch=%0d d=%0h",
                 i, f, c, d, exp_ch[i], exp_d[i]);
      else checks_passed++;
      if (i == 2) begin
        // rr_ptr is 6 now: chan 7 must win over chan 0.
        set_sample(0, 18'h000B0);
        set_sample(7, 18'h000B7);
        tick;
        chan_valid_in = '0;
        pid_valid_in = 1'b1;
        pid_data_in = 64'h55;
        tick;
        pid_valid_in = 1'b0;
      end else begin
        respond(1, 64'(i), dv, dat, ch);
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_result_route;
    bit f; logic [2:0] c; logic [17:0] d;
    logic dv; logic [63:0] dat; logic [2:0] ch;
    tick;
    set_sample(4, 18'h00444);
    tick;
    chan_valid_in = '0;
    wait_issue(f, c, d);
    checks_total++;
    if ({f, c, d} !== {1'b1, 3'd4, 18'h00444})
      $display("FAIL route_issue: got found=%b ch=%0d d=%0h expected ch=4 d=444", f, c, d);
    else checks_passed++;
    respond(4, 64'hDEAD_BEEF, dv, dat, ch);
    checks_total++;
    if ({dv, dat, ch, pid_chan_out} !== {1'b1, 64'hDEAD_BEEF, 3'd4, 3'd4})
      $display("FAIL route_result: got dv=%b d=%0h ch=%0d pch=%0d expected 1/deadbeef/4/4",
               dv, dat, ch, pid_chan_out);
    else checks_passed++;
    tick;
    checks_total++;
    if ({data_valid_out, data_out, chan_out} !== {1'b0, 64'hDEAD_BEEF, 3'd4})
      $display("FAIL route_hold: got dv=%b d=%0h ch=%0d expected 0/deadbeef/4",
               data_valid_out, data_out, chan_out);
    else checks_passed++;
    $display("test_result_route done");
  endtask

  task automatic test_timeout;
    bit f; logic [2:0] c; logic [17:0] d;
    set_sample(6, 18'h00666);
    tick;
    chan_valid_in = '0;
    wait_issue(f, c, d);
    checks_total++;
    if ({f, c} !== {1'b1, 3'd6}) $display("FAIL to_issue: got found=%b ch=%0d expected ch=6", f, c);
    else checks_passed++;
    repeat (9) tick;
    checks_total++;
    if (timeout_out !== 1'b0) $display("FAIL to_early: timeout got %b expected 0", timeout_out);
    else checks_passed++;
    tick;
    checks_total++;
    if ({timeout_out, busy_out} !== 2'b11)
      $display("FAIL to_pulse: got to=%b busy=%b expected 1/1", timeout_out, busy_out);
    else checks_passed++;
    tick;
    checks_total++;
    if ({timeout_out, busy_out} !== 2'b00)
      $display("FAIL to_after: got to=%b busy=%b expected 0/0", timeout_out, busy_out);
    else checks_passed++;
    pid_valid_in = 1'b1;
    pid_data_in = 64'hBAD;
    tick;
    pid_valid_in = 1'b0;
    tick;
    checks_total++;
    if ({data_valid_out, busy_out, data_out} !== {1'b0, 1'b0, 64'hDEAD_BEEF})
      $display("FAIL to_late_drop: got dv=%b busy=%b d=%0h expected 0/0/deadbeef",
               data_valid_out, busy_out, data_out);
    else checks_passed++;
    $display("test_timeout done");
  endtask

  task automatic test_disable;
    bit f; logic [2:0] c; logic [17:0] d;
    logic dv; logic [63:0] dat; logic [2:0] ch;
    set_sample(0, 18'h00100);
    tick;
    chan_valid_in = '0;
    wait_issue(f, c, d);
    set_sample(1, 18'h00111);
    set_sample(4, 18'h00144);
    tick;
    chan_valid_in = '0;
    chan_en_in[1] = 1'b0;
    tick;
    pid_valid_in = 1'b1;
    pid_data_in = 64'h10;
    tick;
    pid_valid_in = 1'b0;
    wait_issue(f, c, d);
    chan_en_in[1] = 1'b1;
    checks_total++;
    if ({f, c, d} !== {1'b1, 3'd4, 18'h00144})
      $display("FAIL disable_skip: got found=%b ch=%0d d=%0h expected ch=4 d=144", f, c, d);
    else checks_passed++;
    respond(1, 64'h44, dv, dat, ch);
    tick;
    wait_issue(f, c, d);
    checks_total++;
    if (f !== 1'b0) $display("FAIL disable_cleared: got issue ch=%0d expected none", c);
    else checks_passed++;
    $display("test_disable done");
  endtask

  task automatic test_back_to_back;
    logic dv; logic [63:0] dat; logic [2:0] ch;
    set_sample(2, 18'h0AAAA);
    tick;
    set_sample(2, 18'h0BBBB);
    tick;
    chan_valid_in = '0;
    checks_total++;
    if ({pid_valid_out, pid_data_out} !== {1'b1, 18'h0AAAA})
      $display("FAIL b2b_first: got v=%b d=%0h expected 1/aaaa", pid_valid_out, pid_data_out);
    else checks_passed++;
    respond(1, 64'h77, dv, dat, ch);
    tick;
    checks_total++;
    if (pid_valid_out !== 1'b0) $display("FAIL b2b_gap: pid_valid got %b expected 0", pid_valid_out);
    else checks_passed++;
    tick;
    checks_total++;
    if ({pid_valid_out, pid_chan_out, pid_data_out} !== {1'b1, 3'd2, 18'h0BBBB})
      $display("FAIL b2b_second: got v=%b ch=%0d d=%0h expected 1/2/bbbb",
               pid_valid_out, pid_chan_out, pid_data_out);
    else checks_passed++;
    respond(1, 64'h78, dv, dat, ch);
    tick;
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid;
    bit f; logic [2:0] c; logic [17:0] d;
    set_sample(5, 18'h00555);
    tick;
    chan_valid_in = '0;
    wait_issue(f, c, d);
    tick;
    tick;
    reset_in = 1'b1;
    pid_valid_in = 1'b1;
    pid_data_in = 64'h99;
    tick;
    checks_total++;
    if ({busy_out, data_valid_out, pid_valid_out, pid_chan_out, pid_data_out, data_out, chan_out} !== '0)
      $display("FAIL reset_mid: got busy=%b dv=%b pch=%0d pd=%0h d=%0h ch=%0d expected all 0",
               busy_out, data_valid_out, pid_chan_out, pid_data_out, data_out, chan_out);
    else checks_passed++;
    reset_in = 1'b0;
    pid_valid_in = 1'b0;
    tick;
    checks_total++;
    if ({busy_out, data_valid_out} !== 2'b00)
      $display("FAIL reset_mid_after: got busy=%b dv=%b expected 0/0", busy_out, data_valid_out);
    else checks_passed++;
    $display("test_reset_mid done");
  endtask

`ifdef PID_SCHED_OVERRUN_EN
  task automatic test_overrun;
    apply_reset;
    set_sample(6, 18'h00601);
    tick;
    set_sample(6, 18'h00602);
    tick;
    chan_valid_in = '0;
    chan_en_in[6] = 1'b0;
    checks_total++;
    if (overrun_out !== 8'h40) $display("FAIL overrun_set: got %0h expected 40", overrun_out);
    else checks_passed++;
    repeat (3) tick;
    checks_total++;
    if (overrun_out !== 8'h40) $display("FAIL overrun_sticky: got %0h expected 40", overrun_out);
    else checks_passed++;
    overrun_clr_in = 1'b1;
    tick;
    overrun_clr_in = 1'b0;
    checks_total++;
    if (overrun_out !== 8'h00) $display("FAIL overrun_clr: got %0h expected 0", overrun_out);
    else checks_passed++;
    chan_en_in = 8'hFF;
    apply_reset;
    $display("test_overrun done");
  endtask
`endif

  initial begin
    reset_in = 1'b1;
    chan_valid_in = '0;
    pid_valid_in = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_result_route;
    test_timeout;
    test_disable;
    test_back_to_back;
    test_reset_mid;
`ifdef PID_SCHED_OVERRUN_EN
    test_overrun;
`endif
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
